// File: rtl/step_dir_pkg.sv
// Shared types and constants for the step/direction generator.
// State encoding, direction levels and prescaler sizing live here.
package step_dir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // At least one bit even when DIV=1, so the counter always has a legal width
  function automatic int prescalerWidth(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/step_dir_gen_if.sv
// Command/status bundle between a motion requester and step_dir_gen.
// The master presents targets and preloads; the slave reports step/dir/pos.
interface step_dir_gen_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             target_ready;
  logic             abort;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] pos;
  logic             busy;
  logic             done;

  modport master (
    output load, in, target, target_valid, abort,
    input  target_ready, step, dir, pos, busy, done
  );

  modport slave (
    input  load, in, target, target_valid, abort,
    output target_ready, step, dir, pos, busy, done
  );

endinterface

// File: rtl/step_prescaler.sv
// Free-running divide-by-DIV counter that flags the last cycle of each step period.
// Holds while disabled; clear restarts the period from zero.
module step_prescaler
  import step_dir_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = prescalerWidth(DIV);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(DIV - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/step_dir_gen.sv
// Walks a position register one unit per DIV cycles toward an accepted target,
// emitting a step pulse and direction level suited to an up/down counter.
module step_dir_gen
  import step_dir_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic           clk,
  input  logic           reset,
  step_dir_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             preClear, preEn, preTick;
  logic             targetReady;

  step_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (preClear),
    .en    (preEn),
    .tick  (preTick)
  );

  assign targetReady = (state_q == IDLE) && !bus.load;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    preClear = 1'b0;
    preEn    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          pos_d = bus.in;
        end else if (bus.target_valid && targetReady) begin
          target_d = bus.target;
          dir_d    = (bus.target > pos_q) ? DIR_UP : DIR_DOWN;
          preClear = 1'b1;
          state_d  = (bus.target == pos_q) ? DONE : MOVE;
        end
      end

      // Abort is checked first so a coincident prescaler tick never produces a step
      MOVE: begin
        if (bus.abort) begin
          preClear = 1'b1;
          state_d  = IDLE;
        end else begin
          preEn = 1'b1;
          if (preTick) begin
            pos_d  = (dir_q == DIR_UP) ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
            step_d = 1'b1;
            if (pos_d == target_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      // A move arrives here with done already raised; a zero-distance accept raises it now
      DONE: begin
        done_d  = !done_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MOVE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      target_q <= '0;
      dir_q    <= DIR_DOWN;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.target_ready = targetReady;
  assign bus.step         = step_q;
  assign bus.dir          = dir_q;
  assign bus.pos          = pos_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Drives a DIV=4 and a DIV=1 instance with identical stimulus and compares every
// cycle against a timeline model built from elapsed cycles since each accept.
module tb_step_dir_gen;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  step_dir_gen_if #(.WIDTH(WIDTH)) busA ();
  step_dir_gen_if #(.WIDTH(WIDTH)) busB ();

  step_dir_gen #(.WIDTH(WIDTH), .DIV(4)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  step_dir_gen #(.WIDTH(WIDTH), .DIV(1)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  logic       curReset;
  logic       curLoad;
  logic [3:0] curIn;
  logic [3:0] curTarget;
  logic       curValid;
  logic       curAbort;

  // Model: phase 0 idle, 1 moving, 2 finishing after last step, 3 zero-distance finish
  int divOf  [2];
  int mPhase [2];
  int mPos   [2];
  int mStart [2];
  int mDist  [2];
  int mT     [2];
  int mDir   [2];
  int mStep  [2];
  int mDone  [2];
  int mBusy  [2];

  int stepsSeen [2];
  int busySeen  [2];
  int doneSeen  [2];

  int testsRun    = 0;
  int testsFailed = 0;
  bit resetSeen   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic readOutputs(input int i, output logic [31:0] st, output logic [31:0] dr,
                             output logic [31:0] ps, output logic [31:0] bz,
                             output logic [31:0] dn, output logic [31:0] rdy);
    if (i == 0) begin
      st  = {31'b0, busA.step};
      dr  = {31'b0, busA.dir};
      ps  = {28'b0, busA.pos};
      bz  = {31'b0, busA.busy};
      dn  = {31'b0, busA.done};
      rdy = {31'b0, busA.target_ready};
    end else begin
      st  = {31'b0, busB.step};
      dr  = {31'b0, busB.dir};
      ps  = {28'b0, busB.pos};
      bz  = {31'b0, busB.busy};
      dn  = {31'b0, busB.done};
      rdy = {31'b0, busB.target_ready};
    end
  endtask

  task automatic modelStep(input int i);
    int d;
    d = divOf[i];
    mStep[i] = 0;
    mDone[i] = 0;
    if (curReset == 1'b0) begin
      mPhase[i] = 0;
      mPos[i]   = 0;
      mDir[i]   = 0;
    end else begin
      case (mPhase[i])
        0: begin
          if (curLoad) begin
            mPos[i] = int'(curIn);
          end else if (curValid) begin
            mStart[i] = mPos[i];
            mDir[i]   = (int'(curTarget) > mPos[i]) ? 1 : 0;
            mDist[i]  = (mDir[i] == 1) ? int'(curTarget) - mPos[i] : mPos[i] - int'(curTarget);
            mT[i]     = 0;
            mPhase[i] = (mDist[i] == 0) ? 3 : 1;
          end
        end
        1: begin
          if (curAbort) begin
            mPhase[i] = 0;
          end else begin
            mT[i]++;
            mPos[i]  = (mDir[i] == 1) ? mStart[i] + mT[i] / d : mStart[i] - mT[i] / d;
            mStep[i] = ((mT[i] % d) == 0) ? 1 : 0;
            if (mT[i] == mDist[i] * d) begin
              mDone[i]  = 1;
              mPhase[i] = 2;
            end
          end
        end
        2: mPhase[i] = 0;
        default: begin
          mDone[i]  = 1;
          mPhase[i] = 0;
        end
      endcase
    end
    mBusy[i] = (mPhase[i] == 1) ? 1 : 0;
  endtask

  task automatic checkInstance(input int i, input bit readyOnly);
    logic [31:0] st, dr, ps, bz, dn, rdy;
    string pfx;
    int expReady;
    pfx = (i == 0) ? "div4" : "div1";
    expReady = (mPhase[i] == 0 && curLoad == 1'b0) ? 1 : 0;
    readOutputs(i, st, dr, ps, bz, dn, rdy);
    if (readyOnly) begin
      checkOutput({pfx, ".ready_pre"}, rdy, expReady);
    end else begin
      checkOutput({pfx, ".step"},  st,  mStep[i]);
      checkOutput({pfx, ".dir"},   dr,  mDir[i]);
      checkOutput({pfx, ".pos"},   ps,  mPos[i]);
      checkOutput({pfx, ".busy"},  bz,  mBusy[i]);
      checkOutput({pfx, ".done"},  dn,  mDone[i]);
      checkOutput({pfx, ".ready"}, rdy, expReady);
      if (st === 32'd1) stepsSeen[i]++;
      if (bz === 32'd1) busySeen[i]++;
      if (dn === 32'd1) doneSeen[i]++;
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic ld, input logic [3:0] inV,
                               input logic [3:0] tgt, input logic tv, input logic ab);
    curReset  = rstN;
    curLoad   = ld;
    curIn     = inV;
    curTarget = tgt;
    curValid  = tv;
    curAbort  = ab;
    reset             = rstN;
    busA.load         = ld;
    busA.in           = inV;
    busA.target       = tgt;
    busA.target_valid = tv;
    busA.abort        = ab;
    busB.load         = ld;
    busB.in           = inV;
    busB.target       = tgt;
    busB.target_valid = tv;
    busB.abort        = ab;
    #1;
    if (resetSeen) begin
      checkInstance(0, 1'b1);
      checkInstance(1, 1'b1);
    end
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    if (!rstN) resetSeen = 1'b1;
    #1;
    checkInstance(0, 1'b0);
    checkInstance(1, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'b0, 1'b0);
    end
  endtask

  task automatic clearCounters();
    for (int i = 0; i < 2; i++) begin
      stepsSeen[i] = 0;
      busySeen[i]  = 0;
      doneSeen[i]  = 0;
    end
  endtask

  initial begin
    divOf[0] = 4;
    divOf[1] = 1;
    for (int i = 0; i < 2; i++) begin
      mPhase[i] = 0; mPos[i] = 0; mStart[i] = 0; mDist[i] = 0; mT[i] = 0;
      mDir[i] = 0; mStep[i] = 0; mDone[i] = 0; mBusy[i] = 0;
    end
    clearCounters();

    // Reset held with load and target_valid asserted, then release
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Preload 10, with a target presented alongside that must be ignored
    applyStimulus(1'b1, 1'b1, 4'd10, 4'd3, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("preload.pos", {28'b0, busA.pos}, 32'd10);

    // Up move 10 -> 13
    clearCounters();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd13, 1'b1, 1'b0);
    idleCycles(14);
    checkOutput("up.steps_div4", stepsSeen[0], 32'd3);
    checkOutput("up.busy_div4",  busySeen[0],  32'd12);
    checkOutput("up.done_div4",  doneSeen[0],  32'd1);
    checkOutput("up.busy_div1",  busySeen[1],  32'd3);
    checkOutput("up.pos_div4",   {28'b0, busA.pos}, 32'd13);

    // Down move 13 -> 2
    clearCounters();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
    idleCycles(46);
    checkOutput("down.steps_div4", stepsSeen[0], 32'd11);
    checkOutput("down.steps_div1", stepsSeen[1], 32'd11);
    checkOutput("down.busy_div1",  busySeen[1],  32'd11);
    checkOutput("down.pos_div4",   {28'b0, busA.pos}, 32'd2);
    checkOutput("down.dir_div4",   {31'b0, busA.dir}, 32'd0);

    // Zero-distance request
    clearCounters();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("zero.steps_div4", stepsSeen[0], 32'd0);
    checkOutput("zero.busy_div4",  busySeen[0],  32'd0);
    checkOutput("zero.done_div4",  doneSeen[0],  32'd1);

    // Abort six cycles into a 10 -> 13 move
    applyStimulus(1'b1, 1'b1, 4'd10, 4'd0, 1'b0, 1'b0);
    clearCounters();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd13, 1'b1, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    idleCycles(3);
    checkOutput("abort.pos_div4",  {28'b0, busA.pos}, 32'd11);
    checkOutput("abort.done_div4", doneSeen[0], 32'd0);
    checkOutput("abort.steps_div4", stepsSeen[0], 32'd1);

    // Reset mid-move, then a clean move to 3
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0);
    idleCycles(5);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("midreset.pos_div4", {28'b0, busA.pos}, 32'd0);
    idleCycles(1);
    clearCounters();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0);
    idleCycles(16);
    checkOutput("after.steps_div4", stepsSeen[0], 32'd3);
    checkOutput("after.done_div4",  doneSeen[0],  32'd1);
    checkOutput("after.pos_div4",   {28'b0, busA.pos}, 32'd3);

    // Randomized traffic, including mid-move target changes, loads and aborts
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 7) == 0),
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Step/direction source that drives an up/down position counter.
- Accepts a target position and moves an internal position register one unit at a time toward it.
- Emits a one-cycle step pulse plus a direction level on every move, at a fixed clock-divided rate.
- Sits upstream of the team's up/down counter blocks: step maps to the count enable, dir maps to the up/down mode.

Parameters:
- WIDTH, 4, bit width of position and target (unsigned).
- DIV, 4, clock cycles per step; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- load  in  1  in IDLE, preload pos from in with no step emitted.
- in  in  WIDTH  preload value.
- target  in  WIDTH  requested position.
- target_valid  in  1  target is presented.
- target_ready  out  1  block can accept a target.
- abort  in  1  stop the current move.
- step  out  1  one-cycle pulse per unit move.
- dir  out  1  1 = up (increment), 0 = down.
- pos  out  WIDTH  current position.
- busy  out  1  high while in MOVE.
- done  out  1  one-cycle pulse when the move completes.

Behaviour:
- Reset is sampled at clk rising edge while reset=0. Resulting values:
  - state IDLE; pos=0; prescaler=0.
  - step=0, dir=0, done=0, busy=0.
- States:
  - IDLE:
    - target_ready = (state==IDLE) && !load, combinational.
    - load=1: pos<=in, state stays IDLE. load wins over target_valid in the same cycle.
    - target_valid && target_ready: latch target, dir<=(target>pos), prescaler<=0. Next state is MOVE if target!=pos, else DONE.
  - MOVE:
    - busy=1; prescaler increments every cycle.
    - When prescaler==DIV-1: prescaler<=0, pos<=pos+1 if dir else pos-1, step<=1 for exactly the next cycle.
    - If the new pos equals the latched target, state<=DONE at that same edge.
  - DONE: done=1 for one cycle, then IDLE.
- Registered outputs: step, done, and busy are registered. The final step pulse and done are high in the same cycle.
- Latency: with accept at edge 0 and N=|target-pos|:
  - step k is visible after edge k*DIV.
  - done is visible after edge N*DIV.
  - Zero distance: done is visible after edge 1 with no step.
- DIV=1: one step every cycle; busy stays high for N cycles.
- Arithmetic: unsigned compare only. pos never wraps, because motion is always toward a latched in-range target.
- target, target_valid, and load are ignored outside IDLE. A target change mid-move has no effect.
- abort in MOVE:
  - Next edge goes to IDLE; pos holds its last value; prescaler clears.
  - No step or done is emitted at that edge.
  - abort is ignored in IDLE and DONE.
- abort coincident with a step edge: abort wins, and no step is issued that edge.
- reset mid-move: all state returns to reset values next edge; any pending step/done is lost.
- dir holds its value after a move until the next accept.

Decomposition:
- Package step_dir_pkg holds:
  - state encoding: IDLE, MOVE, DONE.
  - constants DIR_UP=1, DIR_DOWN=0.
  - function for prescaler width: max(1, clog2(DIV)).
- Sub-module step_prescaler (parameter DIV):
  - inputs clk, reset, clear, en.
  - output tick, high when count==DIV-1.
  - Instantiated once.

Test Plan (WIDTH=4, DIV=4):
- Reset: hold reset=0 for 2 cycles with load=1 and target_valid=1 -> pos=0, step=0, dir=0, done=0, busy=0. After release, target_ready=1.
- Preload: load=1, in=4'b1010 for one cycle in IDLE -> pos=10 next cycle; no step; target_ready=0 during the load cycle.
- Up move: from pos=10, target=13 accepted -> 3 step pulses with dir=1.
  - Steps appear 4, 8, and 12 cycles after accept; pos goes 11, 12, 13.
  - done coincides with the 3rd step; busy is high for 12 cycles.
- Down move: from pos=13, target=2 -> 11 steps, dir=0, pos ends at 2.
  - done appears 44 cycles after accept.
  - Run with DIV=1 too: 11 consecutive step cycles.
- Zero distance: target equal to pos -> no step, done pulse 1 cycle after accept, busy never high.
- Interruptions:
  - abort asserted 6 cycles into the 10->13 move -> pos=11, returns to IDLE, no done.
  - Separately, reset=0 mid-move -> pos=0, outputs return to reset values.
  - A subsequent target=3 move completes normally.
